// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32 control FSM: sequences fetch/decode/execute/memory/write-back
// and drives datapath strobes, with a memory-wait watchdog that traps.
module mc_control_fsm #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        branch_cond,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic        illegal,
    output logic [2:0]  state_o
);

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_TRAP   = 3'd5;

    localparam logic [6:0] OP_RTYPE  = 7'h33;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;

    localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]       state;
    logic [2:0]       state_next;
    logic [6:0]       opcode_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             illegal_q;

    logic is_rtype, is_load, is_store, is_branch;
    logic is_jal, is_jalr, is_auipc;
    logic mem_phase;
    logic mem_wait;
    logic timed_out;

    // Only the opcode field is used here; the rest feeds the datapath.
    logic unused_instr;
    assign unused_instr = ^instr[31:7];

    function automatic logic opcode_legal(input logic [6:0] op);
        case (op)
            OP_RTYPE, OP_LOAD, OP_IMM, OP_JALR, OP_STORE,
            OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    assign is_rtype  = (opcode_q == OP_RTYPE);
    assign is_load   = (opcode_q == OP_LOAD);
    assign is_store  = (opcode_q == OP_STORE);
    assign is_branch = (opcode_q == OP_BRANCH);
    assign is_jal    = (opcode_q == OP_JAL);
    assign is_jalr   = (opcode_q == OP_JALR);
    assign is_auipc  = (opcode_q == OP_AUIPC);

    assign mem_phase = (state == ST_FETCH) || (state == ST_MEM);
    assign mem_wait  = mem_phase && !mem_ready;
    assign timed_out = (wait_cnt == CNT_LAST);

    // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH: begin
                if (mem_ready)      state_next = ST_DECODE;
                else if (timed_out) state_next = ST_TRAP;
            end
            ST_DECODE: state_next = opcode_legal(instr[6:0]) ? ST_EXEC : ST_TRAP;
            ST_EXEC: begin
                if (is_load || is_store) state_next = ST_MEM;
                else if (is_branch)      state_next = ST_FETCH;
                else                     state_next = ST_WB;
            end
            ST_MEM: begin
                if (mem_ready)      state_next = is_load ? ST_WB : ST_FETCH;
                else if (timed_out) state_next = ST_TRAP;
            end
            ST_WB:   state_next = ST_FETCH;
            ST_TRAP: state_next = ST_TRAP;
            default: state_next = ST_TRAP;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FETCH;
            opcode_q  <= '0;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_DECODE) opcode_q <= instr[6:0];
            // Any state change restarts the count, covering entry to FETCH and MEM.
            if (state_next != state) wait_cnt <= '0;
            else if (mem_wait)       wait_cnt <= wait_cnt + 1'b1;
            if (state_next == ST_TRAP) illegal_q <= 1'b1;
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 1'b0;
        reg_we    = 1'b0;
        wb_sel    = WB_ALU;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        if (!rst) begin
            case (state)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we = 1'b1;
                        pc_we = 1'b1;
                    end
                end
                ST_EXEC: begin
                    alu_a_sel = is_branch || is_jal || is_auipc;
                    alu_b_sel = !is_rtype;
                    if (is_branch) begin
                        pc_we  = branch_cond;
                        pc_sel = branch_cond;
                    end
                end
                ST_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = is_store;
                end
                ST_WB: begin
                    reg_we = 1'b1;
                    if (is_load) begin
                        wb_sel = WB_LOAD;
                    end else if (is_jal || is_jalr) begin
                        wb_sel = WB_LINK;
                        pc_we  = 1'b1;
                        pc_sel = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Reset blanks the debug view and the trap flag before the registers clear.
    assign illegal = illegal_q && !rst;
    assign state_o = rst ? 3'd0 : state;

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles to wait for mem_ready per memory access before trapping.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port instr, input, 32, instruction register contents; opcode is instr[6:0].
REQ-005 SHALL have port mem_ready, input, 1, memory completion for the current access.
REQ-006 SHALL have port branch_cond, input, 1, branch comparator result, valid in EXEC.
REQ-007 SHALL have output mem_req, 1, memory access request.
REQ-008 SHALL have output mem_we, 1, store qualifier for mem_req.
REQ-009 SHALL have output ir_we, 1, instruction register load strobe.
REQ-010 SHALL have output pc_we, 1, PC load strobe.
REQ-011 SHALL have output pc_sel, 1, PC source: 0 = PC+4, 1 = ALU target.
REQ-012 SHALL have output reg_we, 1, register file write strobe.
REQ-013 SHALL have output wb_sel, 2, write-back source: 0 = ALU, 1 = load data, 2 = PC+4.
REQ-014 SHALL have output alu_a_sel, 1, ALU A source: 0 = rs1, 1 = PC.
REQ-015 SHALL have output alu_b_sel, 1, ALU B source: 0 = rs2, 1 = immediate.
REQ-016 SHALL have output illegal, 1, sticky trap flag.
REQ-017 SHALL have output state_o, 3, current state encoding for debug.

Function
REQ-018 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; outputs SHALL be decoded from the state register and the opcode latched in DECODE.
REQ-019 FETCH SHALL assert mem_req=1 and mem_we=0 every cycle until mem_ready=1; in that cycle it SHALL assert ir_we=1, pc_we=1 and pc_sel=0, then go to DECODE.
REQ-020 DECODE SHALL latch opcode=instr[6:0], then go to EXEC.
REQ-021 DECODE SHALL go to TRAP instead if the opcode is not one of 33h, 03h, 13h, 67h, 23h, 63h, 37h, 17h, 6Fh.
REQ-022 EXEC SHALL drive the ALU selects per opcode:
- R-type: a=rs1, b=rs2
- I-ALU, load, store, JALR: a=rs1, b=imm
- branch, JAL, AUIPC: a=PC, b=imm
- LUI: b=imm
REQ-023 EXEC transitions SHALL be:
- load or store: go to MEM
- branch: assert pc_we=1 and pc_sel=1 only if branch_cond=1, then go to FETCH
- all other opcodes: go to WB
REQ-024 MEM SHALL hold mem_req=1, with mem_we=1 for stores, until mem_ready=1; it SHALL then go to WB for loads and to FETCH for stores.
REQ-025 WB SHALL assert reg_we=1 for exactly one cycle, then go to FETCH.
- wb_sel: 1 for load, 2 for JAL/JALR, 0 otherwise.
- JAL/JALR SHALL also assert pc_we=1 and pc_sel=1 in the same cycle.
REQ-026 Latency in cycles with zero-wait memory (mem_ready already high on the first request cycle) SHALL be:
- R/I-ALU/LUI/AUIPC/JAL/JALR: 4
- load: 5
- store: 4
- branch: 3
REQ-027 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle mem_req=1 with mem_ready=0; when it reaches TIMEOUT_CYCLES the FSM SHALL go to TRAP.
REQ-028 TRAP SHALL set illegal=1, hold all strobes at 0, and stay in TRAP until rst.
REQ-029 mem_ready SHALL be ignored in DECODE, EXEC, WB and TRAP.
REQ-030 At most one of ir_we, reg_we and mem_we SHALL be high in any cycle.

Reset
REQ-031 While rst=1 at a clock edge, the next state SHALL be FETCH, and the wait counter, latched opcode and illegal SHALL clear to 0.
REQ-032 While rst=1, all outputs SHALL be driven 0 regardless of state.
REQ-033 rst asserted mid-access SHALL abandon the access with no further strobes; mem_req SHALL restart in the first cycle after rst deasserts.

Verification
REQ-034 Bench SHALL cover: add (33h), zero-wait memory -> states 0,1,2,4; reg_we=1 with wb_sel=0 in cycle 4; next FETCH in cycle 5.
REQ-035 Bench SHALL cover: lw (03h), mem_ready delayed 3 cycles in MEM -> mem_req high 4 cycles in MEM; reg_we=1 with wb_sel=1 one cycle after mem_ready.
REQ-036 Bench SHALL cover: beq (63h) with branch_cond=1 -> pc_we=1 and pc_sel=1 in EXEC, return to FETCH; with branch_cond=0 -> pc_we=0 in EXEC.
REQ-037 Bench SHALL cover: opcode 7Fh -> TRAP after DECODE; illegal=1 held for 20 cycles; rst pulse returns to FETCH with illegal=0.
REQ-038 Bench SHALL cover: TIMEOUT_CYCLES=4 with mem_ready held 0 in FETCH -> TRAP entered after the 4th wait cycle.
REQ-039 Bench SHALL cover: rst asserted during MEM of sw -> mem_req=0 while rst=1; FETCH request begins the first cycle after release.
